// File: rtl/grey_pkg.sv
// Shared types and default sizes for the Grey-code converter family.
// Holds the history-tracking state enum used by the pipelined converter.
package grey_pkg;

    localparam int GREY_WIDTH = 4;
    localparam int GREY_ERR_W = 8;

    // IDLE: no previous code stored; TRACK: prev_grey holds the last accepted code.
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } grey_state_t;

endpackage

// File: rtl/grey_to_bin_comb.sv
// Purely combinational Grey-to-binary converter.
// Each binary bit is the XOR of all Grey bits at or above its position.
module grey_to_bin_comb
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH
) (
    input  logic [WIDTH-1:0] grey,
    output logic [WIDTH-1:0] bin
);

    // Reduction form of bin[i] = bin[i+1] ^ g[i]; avoids a self-referencing vector.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^grey[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/grey_to_bin_pipe.sv
// Single-register Grey-to-binary pipeline with valid/ready handshakes,
// single-bit-step checking against the previously accepted code and a saturating error counter.
module grey_to_bin_pipe
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH,
    parameter int ERR_W = GREY_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] grey_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear_hist,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);

    localparam int POP_W = $clog2(WIDTH + 1);

    grey_state_t      r_state;
    logic [WIDTH-1:0] r_prev_grey;
    logic [WIDTH-1:0] r_bin_out;
    logic             r_step_err;
    logic             r_out_valid;
    logic [ERR_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    logic [POP_W-1:0] w_pop;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_step_err;
    logic             w_err_sat;

    grey_to_bin_comb #(
        .WIDTH (WIDTH)
    ) u_conv (
        .grey (grey_in),
        .bin  (w_bin)
    );

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_comb begin
        w_diff = grey_in ^ r_prev_grey;
        w_pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_diff[i]);
        end
    end

    // clear_hist in the same cycle as a transfer makes this word a fresh first sample.
    assign w_step_err = (r_state == TRACK) && !clear_hist && (w_pop != POP_W'(1));
    assign w_err_sat  = (r_err_count == {ERR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev_grey <= '0;
            r_bin_out   <= '0;
            r_step_err  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_count <= '0;
        end else if (w_in_xfer) begin
            r_state     <= TRACK;
            r_prev_grey <= grey_in;
            r_bin_out   <= w_bin;
            r_step_err  <= w_step_err;
            r_out_valid <= 1'b1;
            if (w_step_err && !w_err_sat) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end else begin
            if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (clear_hist) begin
                r_state <= IDLE;
            end
        end
    end

    assign bin_out   = r_bin_out;
    assign step_err  = r_step_err;
    assign out_valid = r_out_valid;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_grey_to_bin_pipe.sv
// Directed and randomized checks of grey_to_bin_pipe against a behavioural model
// (Grey decoded by table search, step distance by bit count, one-entry output buffer).
module tb_grey_to_bin_pipe;

    localparam int W  = 4;
    localparam int EW = 2;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  grey_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          clear_hist = 1'b0;
    logic [W-1:0]  bin_out;
    logic          step_err;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_have_prev = 0;
    int m_prev      = 0;
    bit m_pend      = 0;
    int m_bin       = 0;
    bit m_err       = 0;
    int m_cnt       = 0;

    grey_to_bin_pipe #(
        .WIDTH (W),
        .ERR_W (EW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .grey_in    (grey_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear_hist (clear_hist),
        .bin_out    (bin_out),
        .step_err   (step_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic int gray2bin(input int g);
        for (int n = 0; n < (1 << W); n++) begin
            if ((n ^ (n >> 1)) == g) return n;
        end
        return -1;
    endfunction

    function automatic int bitcount(input int v);
        int c = 0;
        for (int k = 0; k < 32; k++) c += (v >> k) & 1;
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input bit v, input int g, input bit clr, input bit ordy);
        bit exp_rdy;
        bit in_x;
        @(negedge clk);
        in_valid   = v;
        grey_in    = W'(g);
        clear_hist = clr;
        out_ready  = ordy;
        exp_rdy    = !m_pend || ordy;
        #1;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        in_x = v && exp_rdy;
        if (in_x) begin
            m_bin = gray2bin(g);
            m_err = m_have_prev && !clr && (bitcount(g ^ m_prev) != 1);
            if (m_err && m_cnt < ERR_MAX) m_cnt++;
            m_prev      = g;
            m_have_prev = 1;
            m_pend      = 1;
        end else begin
            if (m_pend && ordy) m_pend = 0;
            if (clr) m_have_prev = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(m_pend));
        if (m_pend) begin
            chk("bin_out", int'(bin_out), m_bin);
            chk("step_err", int'(step_err), int'(m_err));
        end
        chk("err_count", int'(err_count), m_cnt);
        $display("step v=%0d g=%0h clr=%0d ordy=%0d -> ov=%0d bin=%0h err=%0d cnt=%0d",
                 v, g, clr, ordy, out_valid, bin_out, step_err, err_count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_hist = 1'b0;
        @(posedge clk);
        #1;
        m_have_prev = 0; m_prev = 0; m_pend = 0; m_bin = 0; m_err = 0; m_cnt = 0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_step_err", int'(step_err), 0);
        $display("reset -> ov=%0d cnt=%0d rdy=%0d", out_valid, err_count, in_ready);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        // Reset state
        do_reset();

        // Continuous flow, legal single steps
        step(1, 4'b0000, 0, 1); chk("s032_bin0", int'(bin_out), 4'b0000);
        step(1, 4'b0001, 0, 1); chk("s032_bin1", int'(bin_out), 4'b0001);
        step(1, 4'b0011, 0, 1); chk("s032_bin2", int'(bin_out), 4'b0010);
        step(1, 4'b0010, 0, 1); chk("s032_bin3", int'(bin_out), 4'b0011);
        chk("s032_cnt", int'(err_count), 0);

        // Distance-2 step then repeated code
        step(1, 4'b0011, 0, 1);
        step(1, 4'b0110, 0, 1); chk("s033_err_a", int'(step_err), 1);
        chk("s033_bin_a", int'(bin_out), 4'b0100);
        step(1, 4'b0110, 0, 1); chk("s033_err_b", int'(step_err), 1);
        chk("s033_cnt", int'(err_count), 2);

        // Reset with an output pending and err_count = 2
        step(0, 0, 0, 0);
        chk("s037_pend", int'(out_valid), 1);
        do_reset();

        // First word after reset, then wrap-around
        step(1, 4'b1000, 0, 1); chk("s035_bin_a", int'(bin_out), 4'b1111);
        chk("s037_first_err", int'(step_err), 0);
        step(1, 4'b0000, 0, 1); chk("s035_bin_b", int'(bin_out), 4'b0000);
        chk("s035_err_b", int'(step_err), 0);
        step(0, 0, 0, 1);

        // Backpressure: accept one word, hold the next for 3 cycles
        step(1, 4'b0001, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0011, 0, 0);
            chk("s034_hold", int'(bin_out), 4'b0001);
        end
        step(1, 4'b0011, 0, 1); chk("s034_next", int'(bin_out), 4'b0010);
        step(0, 0, 0, 1);
        chk("s034_nodup", int'(out_valid), 0);

        // clear_hist alone leaves outputs untouched, then history restarts
        step(1, 4'b0000, 0, 1);
        step(0, 0, 1, 0);
        chk("s025_bin", int'(bin_out), 4'b0000);
        step(1, 4'b1111, 0, 1); chk("clr_first_err", int'(step_err), 0);

        // clear_hist with a concurrent accept, then saturation
        step(1, 4'b0000, 0, 1);
        step(1, 4'b0101, 1, 1); chk("s036_clr_err", int'(step_err), 0);
        for (int i = 0; i < 5; i++) step(1, 4'b0101, 0, 1);
        chk("s036_sat", int'(err_count), ERR_MAX);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) g = m_prev ^ (1 << $urandom_range(0, W - 1));
            else g = int'($urandom_range(0, (1 << W) - 1));
            step(bit'($urandom_range(0, 3) != 0), g,
                 bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grey_to_bin_pipe.md
GREY_TO_BIN_PIPE -- requirements
Module: grey_to_bin_pipe

Interface
REQ-001 Parameter: WIDTH, default 4, code width in bits (legal range 2..16).
REQ-002 Parameter: ERR_W, default 8, width of the error counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: grey_in  input  WIDTH  Grey-coded input word.
REQ-006 Port: in_valid  input  1  grey_in is valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts grey_in this cycle.
REQ-008 Port: clear_hist  input  1  discard the stored previous code and return to IDLE.
REQ-009 Port: bin_out  output  WIDTH  binary equivalent of the accepted word.
REQ-010 Port: step_err  output  1  accepted word was not a single-bit step from the previous word; qualified by out_valid.
REQ-011 Port: out_valid  output  1  bin_out and step_err are valid.
REQ-012 Port: out_ready  input  1  downstream consumes the output this cycle.
REQ-013 Port: err_count  output  ERR_W  saturating count of step errors since reset.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), which gives a single-register pipeline with no bubble under continuous flow.
REQ-016 On an input transfer, bin_out SHALL load bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] XOR g[i], with out_valid high on the next cycle (latency 1).
REQ-017 out_valid, bin_out and step_err SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 out_valid SHALL clear after an output transfer that has no simultaneous input transfer.
REQ-019 The FSM SHALL have two states. IDLE means no previous code is stored. TRACK means a previous code is stored in prev_grey.
REQ-020 IDLE -> TRACK SHALL occur on an input transfer, storing grey_in in prev_grey with step_err = 0.
REQ-021 In TRACK, an input transfer SHALL set step_err = 1 when popcount(grey_in XOR prev_grey) != 1, including a repeated identical code, and SHALL then update prev_grey.
REQ-022 Wrap-around SHALL be a legal step: all-ones binary to zero (Grey 1000 -> 0000 for WIDTH=4) gives step_err = 0.
REQ-023 err_count SHALL increment by 1 on each input transfer that produces step_err = 1, and SHALL saturate at 2^ERR_W-1.
REQ-024 clear_hist SHALL force the state to IDLE. If an input transfer occurs in the same cycle, that word SHALL be treated as an IDLE first sample (step_err = 0, state ends in TRACK).
REQ-025 clear_hist SHALL NOT affect out_valid, bin_out or err_count.

Reset
REQ-026 On rst, the following SHALL take effect on the next rising edge: state = IDLE, prev_grey = 0, out_valid = 0, bin_out = 0, step_err = 0, err_count = 0.
REQ-027 rst SHALL override all other inputs. An output pending at reset SHALL be dropped, not delivered.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid = 0.

Structure
REQ-029 A shared package grey_pkg SHALL hold the state enum (IDLE, TRACK) and the default constants GREY_WIDTH = 4 and GREY_ERR_W = 8.
REQ-030 The Grey-to-binary XOR chain SHALL be a combinational sub-module named grey_to_bin_comb, so it can be reused by other converter blocks.
REQ-031 The popcount/step check SHALL stay inside grey_to_bin_pipe.

Verification
REQ-032 Scenario: out_ready = 1, feed Grey 0000, 0001, 0011, 0010 -> bin_out 0000, 0001, 0010, 0011, one cycle after each transfer, all step_err = 0, err_count = 0.
REQ-033 Scenario: after 0011, feed 0110 (distance 2), then 0110 again (distance 0) -> bin_out 0100 with step_err = 1, then 0100 with step_err = 1; err_count = 2.
REQ-034 Scenario: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 after the first accept, bin_out held, no word lost or duplicated when out_ready returns to 1.
REQ-035 Scenario: Grey 1000 then 0000 -> bin_out 1111 then 0000, step_err = 0 for both.
REQ-036 Scenario: clear_hist together with an accepted 0101 after prev_grey = 0000 -> step_err = 0; set ERR_W = 2 and inject 5 errors -> err_count sticks at 3.
REQ-037 Scenario: assert rst while out_valid = 1 and err_count = 2 -> next cycle out_valid = 0, err_count = 0, in_ready = 1; the first word after reset gives step_err = 0.
